// File: rtl/mac_tile_sched.sv
// Sequencer for a ROWS x COLS FP8 MAC tile: skewed operand feed, result wait, raster-order drain.
// Optional WAIT watchdog enabled by defining MAC_TILE_SCHED_TIMEOUT_EN.
module mac_tile_sched #(
  parameter int unsigned ROWS        = 4,
  parameter int unsigned COLS        = 4,
  parameter int unsigned K_MAX       = 16,
  parameter int unsigned KW          = 5,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [KW-1:0]             i_k_len,
  input  logic                      i_mode_fp8_cfg,
  input  logic                      i_feed_stall,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_err_cfg,
  output logic                      o_err_timeout,
  output logic                      o_mode_fp8,
  output logic                      o_op_rd_en,
  output logic [KW-1:0]             o_op_rd_k,
  output logic [ROWS-1:0]           o_row_valid,
  input  logic [ROWS*COLS-1:0]      i_cell_done,
  input  logic [ROWS*COLS*16-1:0]   i_cell_result,
  output logic [ROWS*COLS-1:0]      o_cell_ack,
  output logic                      o_res_valid,
  input  logic                      i_res_ready,
  output logic [15:0]               o_res_data,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] o_res_row,
  output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] o_res_col
);

  localparam int unsigned NCELL = ROWS * COLS;
  localparam int unsigned IW    = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [KW-1:0] KMaxW = KW'(K_MAX);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFeed  = 3'd1;
  localparam logic [2:0] StSkew  = 3'd2;
  localparam logic [2:0] StWait  = 3'd3;
  localparam logic [2:0] StDrain = 3'd4;

  if (K_MAX >= (1 << KW) || K_MAX == 0 || TIMEOUT_CYC == 0) begin : g_bad_params
    $error("mac_tile_sched: illegal parameter combination");
  end

  logic [2:0]      r_state;
  logic [KW-1:0]   r_t;
  logic [KW-1:0]   r_klen;
  logic            r_mode;
  logic [ROWS-1:0] r_skew;
  logic [RW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic            r_done;
  logic            r_err_cfg;

  logic            w_feed;
  logic            w_issue;
  logic            w_drain;
  logic            w_hs;
  logic            w_last;
  logic            w_cfg_ok;
  logic [IW-1:0]   w_idx;

  assign w_feed   = (r_state == StFeed);
  assign w_issue  = w_feed & ~i_feed_stall;
  assign w_drain  = (r_state == StDrain);
  assign w_hs     = w_drain & i_res_ready;
  assign w_idx    = IW'(r_row) * IW'(COLS) + IW'(r_col);
  assign w_last   = (r_row == RW'(ROWS - 1)) && (r_col == CW'(COLS - 1));
  assign w_cfg_ok = (i_k_len != '0) && (i_k_len <= KMaxW);

`ifdef MAC_TILE_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_wait_cnt;
  logic          r_err_timeout;
  assign o_err_timeout = r_err_timeout;
`else
  assign o_err_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_t       <= '0;
      r_klen    <= '0;
      r_mode    <= 1'b0;
      r_skew    <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_done    <= 1'b0;
      r_err_cfg <= 1'b0;
`ifdef MAC_TILE_SCHED_TIMEOUT_EN
      r_wait_cnt    <= '0;
      r_err_timeout <= 1'b0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_err_cfg <= 1'b0;
`ifdef MAC_TILE_SCHED_TIMEOUT_EN
      r_err_timeout <= 1'b0;
`endif
      // Bit r carries the read enable delayed by 1+r cycles; stalls become bubbles.
      r_skew <= (r_skew << 1) | ROWS'(w_issue);
      case (r_state)
        StIdle: begin
          if (i_start) begin
            if (w_cfg_ok) begin
              r_klen  <= i_k_len;
              r_mode  <= i_mode_fp8_cfg;
              r_t     <= '0;
              r_state <= StFeed;
            end else begin
              r_err_cfg <= 1'b1;
            end
          end
        end
        StFeed: begin
          if (w_issue) begin
            r_t <= r_t + KW'(1);
            if (r_t == r_klen - KW'(1)) r_state <= StSkew;
          end
        end
        StSkew: begin
          if (r_skew == '0) begin
            r_state <= StWait;
`ifdef MAC_TILE_SCHED_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
          end
        end
        StWait: begin
          if (&i_cell_done) begin
            r_row   <= '0;
            r_col   <= '0;
            r_state <= StDrain;
          end
`ifdef MAC_TILE_SCHED_TIMEOUT_EN
          else if (r_wait_cnt == TW'(TIMEOUT_CYC - 1)) begin
            r_err_timeout <= 1'b1;
            r_state       <= StIdle;
          end else begin
            r_wait_cnt <= r_wait_cnt + TW'(1);
          end
`endif
        end
        StDrain: begin
          if (w_hs) begin
            if (w_last) begin
              r_row   <= '0;
              r_col   <= '0;
              r_done  <= 1'b1;
              r_state <= StIdle;
            end else if (r_col == CW'(COLS - 1)) begin
              r_col <= '0;
              r_row <= r_row + RW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    o_res_data = '0;
    o_cell_ack = '0;
    for (int i = 0; i < int'(NCELL); i++) begin
      if (w_drain && (w_idx == IW'(i))) begin
        o_res_data    = i_cell_result[i*16 +: 16];
        // Never acknowledge a cell in a cycle that is being reset away.
        o_cell_ack[i] = w_hs & ~i_rst;
      end
    end
  end

  assign o_busy      = (r_state != StIdle);
  assign o_done      = r_done;
  assign o_err_cfg   = r_err_cfg;
  assign o_mode_fp8  = r_mode;
  assign o_op_rd_en  = w_issue;
  assign o_op_rd_k   = w_feed ? r_t : '0;
  assign o_row_valid = r_skew;
  assign o_res_valid = w_drain;
  assign o_res_row   = w_drain ? r_row : '0;
  assign o_res_col   = w_drain ? r_col : '0;

endmodule

// File: tb/tb_mac_tile_sched.sv
// Randomized self-checking bench for mac_tile_sched, default build (watchdog disabled).
module tb_mac_tile_sched;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int NCELL = ROWS * COLS;
  localparam int KW    = 5;
  localparam int MAXC  = 512;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic [KW-1:0]         k_len;
  logic                  mode_cfg;
  logic                  feed_stall;
  logic                  busy;
  logic                  done;
  logic                  err_cfg;
  logic                  err_timeout;
  logic                  mode_fp8;
  logic                  op_rd_en;
  logic [KW-1:0]         op_rd_k;
  logic [ROWS-1:0]       row_valid;
  logic [NCELL-1:0]      cell_done;
  logic [NCELL*16-1:0]   cell_result;
  logic [NCELL-1:0]      cell_ack;
  logic                  res_valid;
  logic                  res_ready;
  logic [15:0]           res_data;
  logic [1:0]            res_row;
  logic [1:0]            res_col;

  int n_chk = 0;
  int n_err = 0;
  bit exp_done_next = 1'b0;

  mac_tile_sched #(
    .ROWS(ROWS), .COLS(COLS), .K_MAX(16), .KW(KW), .TIMEOUT_CYC(1024)
  ) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_k_len(k_len),
    .i_mode_fp8_cfg(mode_cfg), .i_feed_stall(feed_stall),
    .o_busy(busy), .o_done(done), .o_err_cfg(err_cfg), .o_err_timeout(err_timeout),
    .o_mode_fp8(mode_fp8), .o_op_rd_en(op_rd_en), .o_op_rd_k(op_rd_k),
    .o_row_valid(row_valid), .i_cell_done(cell_done), .i_cell_result(cell_result),
    .o_cell_ack(cell_ack), .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_res_data(res_data), .o_res_row(res_row), .o_res_col(res_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {busy, done, err_cfg, err_timeout, mode_fp8, op_rd_en, op_rd_k,
                          row_valid, res_valid, res_row, res_col}, 64'd0);
    check({tag, "_data"}, {32'd0, res_data, cell_ack}, 64'd0);
  endtask

  // One job: cycle 0 presents start; the expected trace is derived from the issue schedule.
  task automatic run_job(input int klen, input bit mode, input int stall_mode,
                         input int ready_mode, input int dcyc);
    bit               issue_at[MAXC];
    int               kidx[MAXC];
    bit               st[MAXC];
    logic [NCELL*16-1:0] res;
    logic [ROWS-1:0]  exp_rv;
    logic [15:0]      pd;
    int c, k, last, wentry, ds, n;
    bit rdy, ok;
    for (int i = 0; i < MAXC; i++) begin
      issue_at[i] = 1'b0;
      kidx[i]     = 0;
      case (stall_mode)
        0:       st[i] = 1'b0;
        1:       st[i] = (i == 2 || i == 3);
        default: st[i] = ($urandom_range(0, 3) == 0);
      endcase
    end
    k = 0;
    c = 1;
    while (k < klen) begin
      if (!st[c]) begin
        issue_at[c] = 1'b1;
        kidx[c]     = k;
        k++;
      end
      c++;
    end
    last   = c - 1;
    wentry = last + ROWS + 2;
    ds     = ((dcyc > wentry) ? dcyc : wentry) + 1;
    for (int i = 0; i < NCELL * 16 / 32; i++) res[i*32 +: 32] = $urandom;
    n  = 0;
    ok = 1'b0;
    for (c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      start       = (c == 0);
      k_len       = (c == 0) ? KW'(klen) : KW'($urandom_range(0, 31));
      mode_cfg    = (c == 0) ? mode : 1'($urandom);
      feed_stall  = st[c];
      cell_result = res;
      if (c >= ds) cell_done = 16'($urandom);
      else if (c >= dcyc) cell_done = '1;
      else begin
        pd = 16'($urandom);
        pd[$urandom_range(0, 15)] = 1'b0;
        cell_done = pd;
      end
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (c >= ds) ? (((c - ds) % 4 == 0) || ((c - ds) % 4 == 3)) : 1'($urandom);
        default: rdy = 1'($urandom);
      endcase
      res_ready = rdy;
      @(negedge clk);
      if (c == 0) begin
        check("c0_busy", busy, 0);
        check("c0_done", done, exp_done_next);
        check("c0_rd_en", op_rd_en, 0);
        exp_done_next = 1'b0;
      end else begin
        check("op_rd_en", op_rd_en, issue_at[c]);
        if (issue_at[c]) check("op_rd_k", op_rd_k, kidx[c]);
        for (int r = 0; r < ROWS; r++) exp_rv[r] = (c - 1 - r >= 0) ? issue_at[c-1-r] : 1'b0;
        check("row_valid", row_valid, exp_rv);
        check("busy", busy, 1);
        check("done", done, 0);
        check("err", {err_cfg, err_timeout}, 0);
        check("mode_fp8", mode_fp8, mode);
        check("res_valid", res_valid, (c >= ds));
        if (c >= ds) begin
          check("res_data", res_data, res[n*16 +: 16]);
          check("res_row", res_row, n / COLS);
          check("res_col", res_col, n % COLS);
          check("cell_ack", cell_ack, rdy ? (64'd1 << n) : 64'd0);
          if (rdy) begin
            n++;
            if (n == NCELL) begin
              ok = 1'b1;
              break;
            end
          end
        end else begin
          check("cell_ack_idle", cell_ack, 0);
        end
      end
    end
    if (!ok) check("drain_complete", n, NCELL);
    exp_done_next = ok;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      start      = 1'b0;
      feed_stall = 1'($urandom);
      @(negedge clk);
      check("idle_done", done, (i == 0) ? exp_done_next : 1'b0);
      check("idle_busy", busy, 0);
      check("idle_out", {op_rd_en, res_valid, row_valid}, 0);
      exp_done_next = 1'b0;
    end
  endtask

  task automatic bad_start(input int klen);
    int errs;
    bit busy_seen, rd_seen;
    errs      = 0;
    busy_seen = 1'b0;
    rd_seen   = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      start      = (c == 0);
      k_len      = KW'(klen);
      feed_stall = 1'b0;
      @(negedge clk);
      if (c == 0) check("bad_c0_done", done, exp_done_next);
      exp_done_next = 1'b0;
      errs += int'(err_cfg);
      busy_seen |= busy;
      rd_seen   |= op_rd_en;
    end
    check("err_cfg_pulses", errs, 1);
    check("bad_busy", busy_seen, 0);
    check("bad_rd_en", rd_seen, 0);
  endtask

  task automatic reset_mid();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      start      = (c == 0);
      k_len      = 5'd5;
      mode_cfg   = 1'b1;
      feed_stall = 1'b0;
      rst        = (c == 3);
      @(negedge clk);
      if (c == 0) check("rm_c0_done", done, exp_done_next);
      exp_done_next = 1'b0;
      if (c == 3) check("rm_rd_k_t2", op_rd_k, 2);
      if (c == 4) check_all_zero("mid_rst");
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; mode_cfg = 1'b0; feed_stall = 1'b0;
    cell_done = '0; cell_result = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    run_job(3, 1'b1, 0, 0, 10);
    run_job(4, 1'b0, 1, 2, 0);
    bad_start(0);
    bad_start(17);
    run_job(5, 1'b1, 0, 1, 0);
    reset_mid();
    run_job(16, 1'b0, 2, 2, $urandom_range(0, 30));
    for (int j = 0; j < 6; j++) begin
      run_job($urandom_range(1, 16), 1'($urandom), 2, 2, $urandom_range(0, 40));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
